spi_master: RTL

- Byte-wide SPI mode-0 master for the external flash.
- Sits on the MMIO bus at core prefix 6'h05 and consumes the decoded cs/we/address/write_data strobes from the top-level memory controller.
- Replaces the current constant tie-offs on spi_ss/spi_sck/spi_mosi.
- Firmware drives chip select, loads a byte, starts a transfer, polls status and reads the received byte.

---
 rtl/spi_master_pkg.sv | 20 ++
 rtl/spi_bit_engine.sv | 101 ++++++++++
 rtl/spi_master.sv | 92 +++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI mode-0 master: register word addresses,
// bit-engine state encodings and the reset value of the clock divider.
package spi_master_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_START  = 8'h0a;
  localparam logic [7:0] ADDR_TX     = 8'h0b;
  localparam logic [7:0] ADDR_RX     = 8'h0c;
  localparam logic [7:0] ADDR_CLKDIV = 8'h0d;

  localparam logic [7:0] DEFAULT_CLKDIV = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'h0,
    ST_LOW  = 2'h1,
    ST_HIGH = 2'h2
  } spi_state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// Serial engine for one MSB-first mode-0 byte: SCK divider, bit counter and
// shift register. MISO is sampled on each rising SCK, MOSI changes on falling.
module spi_bit_engine
  import spi_master_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] clkdiv,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx,
  output logic       idle
);

  spi_state_e state, state_next;
  logic [7:0] div_ctr, div_ctr_next;
  logic [7:0] shift, shift_next;
  logic [7:0] rx_next;
  logic [2:0] bit_ctr, bit_ctr_next;
  logic       sck_next, mosi_next;
  logic       div_done;

  // Compare before incrementing, so clkdiv=8'hff never wraps the counter.
  assign div_done = (div_ctr == clkdiv);
  assign idle     = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      div_ctr <= 8'h00;
      bit_ctr <= 3'd0;
      shift   <= 8'h00;
      rx      <= 8'h00;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_next;
      div_ctr <= div_ctr_next;
      bit_ctr <= bit_ctr_next;
      shift   <= shift_next;
      rx      <= rx_next;
      sck     <= sck_next;
      mosi    <= mosi_next;
    end
  end

  always_comb begin
    state_next   = state;
    div_ctr_next = div_ctr;
    bit_ctr_next = bit_ctr;
    shift_next   = shift;
    rx_next      = rx;
    sck_next     = sck;
    mosi_next    = mosi;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_LOW;
          mosi_next    = tx[7];
          sck_next     = 1'b0;
          bit_ctr_next = 3'd0;
          div_ctr_next = 8'h00;
          shift_next   = tx;
        end
      end
      ST_LOW: begin
        if (div_done) begin
          state_next   = ST_HIGH;
          sck_next     = 1'b1;
          shift_next   = {shift[6:0], miso};
          div_ctr_next = 8'h00;
        end else begin
          div_ctr_next = div_ctr + 8'h01;
        end
      end
      ST_HIGH: begin
        if (div_done) begin
          sck_next     = 1'b0;
          div_ctr_next = 8'h00;
          if (bit_ctr == 3'd7) begin
            state_next = ST_IDLE;
            rx_next    = shift;
            mosi_next  = 1'b0;
          end else begin
            // The next outgoing bit has already shifted up into bit 7.
            state_next   = ST_LOW;
            mosi_next    = shift[7];
            bit_ctr_next = bit_ctr + 3'd1;
          end
        end else begin
          div_ctr_next = div_ctr + 8'h01;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/spi_master.sv
// MMIO-mapped byte-wide SPI mode-0 flash master: register file, bus decode and SS.
// Optional SPI_MASTER_APP_LOCK_EN blocks writes and RX reads while fw_app_mode=1.
module spi_master
  import spi_master_pkg::*;
#(
  parameter logic [7:0] DEFAULT_CLKDIV = spi_master_pkg::DEFAULT_CLKDIV
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  logic       ss_en;
  logic [7:0] tx;
  logic [7:0] clkdiv;
  logic [7:0] rx;
  logic       idle;
  logic       lock;
  logic       wr_ok;
  logic       start;
  logic       unused_bits;

`ifdef SPI_MASTER_APP_LOCK_EN
  assign lock = fw_app_mode;
`else
  assign lock = 1'b0;
`endif

  assign unused_bits = ^{fw_app_mode, write_data[31:8]};

  // Every register write, START included, is dropped while a byte is in flight.
  assign wr_ok = cs && we && idle && !lock;
  assign start = wr_ok && (address == ADDR_START);
  assign ready = cs;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ss_en  <= 1'b0;
      spi_ss <= 1'b1;
      tx     <= 8'h00;
      clkdiv <= DEFAULT_CLKDIV;
    end else if (wr_ok) begin
      case (address)
        ADDR_CTRL: begin
          ss_en  <= write_data[0];
          spi_ss <= ~write_data[0];
        end
        ADDR_TX:     tx     <= write_data[7:0];
        ADDR_CLKDIV: clkdiv <= write_data[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (cs) begin
      case (address)
        ADDR_CTRL:   read_data[0]   = ss_en;
        ADDR_STATUS: read_data[0]   = idle;
        ADDR_TX:     read_data[7:0] = tx;
        ADDR_RX:     read_data[7:0] = lock ? 8'h00 : rx;
        ADDR_CLKDIV: read_data[7:0] = clkdiv;
        default: ;
      endcase
    end
  end

  spi_bit_engine u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tx      (tx),
    .clkdiv  (clkdiv),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .rx      (rx),
    .idle    (idle)
  );

endmodule
